// File: rtl/relogio_ajuste_ctrl.sv
// ---------------------------------------------------------------------------
// relogio_ajuste_ctrl
//
// Control block for the hh:mm:ss BCD time counter.
//   * RUN mode: generates a one-cycle count enable (tick) every CLK_HZ cycles.
//   * Adjust mode: the set button steps through hours -> minutes -> seconds.
//     Each press commits the switch value, clamped to the field range and
//     split into BCD digits, as a one-cycle load command for the field being
//     left.
//   * While adjusting, a blink mask flashes the field currently selected.
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   adjust      in   raw level, high requests adjust mode
//   set         in   raw push button, rising edge commits and advances
//   sw[5:0]     in   raw binary value to load (0..63)
//   tick        out  one-cycle count enable (RUN only)
//   load_en     out  one-cycle load strobe
//   load_field  out  0=hours, 1=minutes, 2=seconds
//   load_tens   out  BCD tens digit of the committed value
//   load_units  out  BCD units digit of the committed value
//   mode        out  0=RUN, 1=ADJ_H, 2=ADJ_M, 3=ADJ_S
//   blink_mask  out  bit2=hours, bit1=minutes, bit0=seconds (1 = blank)
// ---------------------------------------------------------------------------
module relogio_ajuste_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int BLINK_DIV       = 12500000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       adjust,
    input  logic       set,
    input  logic [5:0] sw,
    output logic       tick,
    output logic       load_en,
    output logic [1:0] load_field,
    output logic [3:0] load_tens,
    output logic [3:0] load_units,
    output logic [1:0] mode,
    output logic [2:0] blink_mask
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ADJ_H = 2'd1,
        ADJ_M = 2'd2,
        ADJ_S = 2'd3
    } state_t;

    localparam int PRESC_W = $clog2(CLK_HZ);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
    localparam logic [DB_W-1:0]    DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic state_t next_field(input state_t s);
        case (s)
            ADJ_H:   return ADJ_M;
            ADJ_M:   return ADJ_S;
            default: return ADJ_H;
        endcase
    endfunction

    function automatic logic [2:0] field_onehot(input state_t s);
        case (s)
            ADJ_H:   return 3'b100;
            ADJ_M:   return 3'b010;
            ADJ_S:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] field_index(input state_t s);
        case (s)
            ADJ_M:   return 2'd1;
            ADJ_S:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // Binary 0..59 to two BCD digits by repeated subtraction of ten.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 0; i < 5; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    // -----------------------------------------------------------------------
    // Input synchronisers
    // -----------------------------------------------------------------------
    logic       adjust_s1, adjust_s;
    logic       set_s1, set_s;
    logic [5:0] sw_s1, sw_s;
    logic [1:0] sync_valid;

    // NOTE: every sequential block uses non-blocking assignments so all
    // registers sample the pre-edge values and simulation matches hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adjust_s1  <= 1'b0;
            adjust_s   <= 1'b0;
            set_s1     <= 1'b0;
            set_s      <= 1'b0;
            sw_s1      <= 6'd0;
            sw_s       <= 6'd0;
            sync_valid <= 2'b00;
        end else begin
            adjust_s1  <= adjust;
            adjust_s   <= adjust_s1;
            set_s1     <= set;
            set_s      <= set_s1;
            sw_s1      <= sw;
            sw_s       <= sw_s1;
            sync_valid <= {sync_valid[0], 1'b1};
        end
    end

    // -----------------------------------------------------------------------
    // Set debounce and edge detect
    // -----------------------------------------------------------------------
    logic            set_db, set_db_q, set_armed;
    logic [DB_W-1:0] db_cnt;
    logic            set_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            set_db    <= 1'b0;
            set_db_q  <= 1'b0;
            set_armed <= 1'b0;
            db_cnt    <= '0;
        end else begin
            set_db_q <= set_db;
            if (set_s != set_db) begin
                if (db_cnt == DB_MAX) begin
                    set_db <= set_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
            // A button still held through reset must not count as a press:
            // only arm once the synchronised button has been seen released.
            if (sync_valid[1] && !set_s && !set_db)
                set_armed <= 1'b1;
        end
    end

    assign set_pulse = set_db & ~set_db_q & set_armed;

    // -----------------------------------------------------------------------
    // Commit value: clamp to the field range, then split into BCD
    // -----------------------------------------------------------------------
    state_t     state;
    logic [5:0] commit_val;
    logic [7:0] commit_bcd;

    // NOTE: combinational blocks assign a default first so no path leaves the
    // output unassigned, which would otherwise infer a latch.
    always_comb begin
        commit_val = sw_s;
        if (state == ADJ_H) begin
            if (sw_s > 6'd23)
                commit_val = 6'd23;
        end else if (sw_s > 6'd59) begin
            commit_val = 6'd59;
        end
    end

    assign commit_bcd = to_bcd(commit_val);

    // -----------------------------------------------------------------------
    // Mode FSM, load command and blink generation
    // -----------------------------------------------------------------------
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_state;
    state_t             adv_state;

    assign adv_state = next_field(state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            load_en     <= 1'b0;
            load_field  <= 2'd0;
            load_tens   <= 4'd0;
            load_units  <= 4'd0;
            blink_cnt   <= '0;
            blink_state <= 1'b0;
            blink_mask  <= 3'b000;
        end else begin
            load_en <= 1'b0;
            if (state == RUN) begin
                blink_cnt   <= '0;
                blink_state <= 1'b0;
                blink_mask  <= 3'b000;
                if (adjust_s) begin
                    // Entering adjust: the hours field blanks straight away.
                    state       <= ADJ_H;
                    blink_state <= 1'b1;
                    blink_mask  <= field_onehot(ADJ_H);
                end
            end else if (!adjust_s) begin
                // Leaving adjust wins over a simultaneous press; the switch
                // value is discarded.
                state       <= RUN;
                blink_cnt   <= '0;
                blink_state <= 1'b0;
                blink_mask  <= 3'b000;
            end else if (set_pulse) begin
                state                    <= adv_state;
                load_en                  <= 1'b1;
                load_field               <= field_index(state);
                {load_tens, load_units}  <= commit_bcd;
                blink_cnt                <= '0;
                blink_state              <= 1'b1;
                blink_mask               <= field_onehot(adv_state);
            end else if (blink_cnt == BLINK_MAX) begin
                blink_cnt   <= '0;
                blink_state <= ~blink_state;
                blink_mask  <= blink_state ? 3'b000 : field_onehot(state);
            end else begin
                blink_cnt  <= blink_cnt + BLINK_W'(1);
                blink_mask <= blink_state ? field_onehot(state) : 3'b000;
            end
        end
    end

    assign mode = state;

    // -----------------------------------------------------------------------
    // 1 Hz prescaler
    // -----------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_cnt, presc_next;

    always_comb begin
        presc_next = '0;
        if (state == RUN && presc_cnt != PRESC_MAX)
            presc_next = presc_cnt + PRESC_W'(1);
    end

    // tick is registered: it is high in the cycle where the count sits at
    // its terminal value while in RUN. The FSM is in RUN next cycle exactly
    // when the synchronised adjust is low, whatever the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt <= '0;
            tick      <= 1'b0;
        end else begin
            presc_cnt <= presc_next;
            tick      <= !adjust_s && (presc_next == PRESC_MAX);
        end
    end

endmodule

// File: tb/tb_relogio_ajuste_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for relogio_ajuste_ctrl with CLK_HZ=10, BLINK_DIV=4,
// DEBOUNCE_CYCLES=3. Inputs change and outputs are sampled 1 time unit after
// the falling clock edge. A monitor records ticks and load strobes with the
// index of the rising edge that produced them.
// ---------------------------------------------------------------------------
module tb_relogio_ajuste_ctrl;

    logic       clk;
    logic       reset;
    logic       adjust;
    logic       set;
    logic [5:0] sw;
    logic       tick;
    logic       load_en;
    logic [1:0] load_field;
    logic [3:0] load_tens;
    logic [3:0] load_units;
    logic [1:0] mode;
    logic [2:0] blink_mask;

    relogio_ajuste_ctrl #(
        .CLK_HZ          (10),
        .BLINK_DIV       (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .adjust     (adjust),
        .set        (set),
        .sw         (sw),
        .tick       (tick),
        .load_en    (load_en),
        .load_field (load_field),
        .load_tens  (load_tens),
        .load_units (load_units),
        .mode       (mode),
        .blink_mask (blink_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    int tick_cnt = 0;
    int tick_edge = -1;
    int ld_cnt = 0;
    int ld_edge = -1;
    logic [1:0] ld_f = 2'd0;
    logic [3:0] ld_t = 4'd0;
    logic [3:0] ld_u = 4'd0;

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        if (tick === 1'b1) begin
            tick_cnt++;
            tick_edge = edge_cnt;
        end
        if (load_en === 1'b1) begin
            ld_cnt++;
            ld_edge = edge_cnt;
            ld_f = load_field;
            ld_t = load_tens;
            ld_u = load_units;
        end
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    int e0, l0, t0;

    initial begin
        reset  = 1'b1;
        adjust = 1'b0;
        set    = 1'b0;
        sw     = 6'd0;
        cyc(3);

        // Reset state
        chk("rst_tick", tick, 0);
        chk("rst_load_en", load_en, 0);
        chk("rst_field", load_field, 0);
        chk("rst_tens", load_tens, 0);
        chk("rst_units", load_units, 0);
        chk("rst_mode", mode, 0);
        chk("rst_mask", blink_mask, 0);

        // RUN: ticks every 10 cycles, first in the 10th cycle after reset
        reset = 1'b0;
        e0 = edge_cnt; t0 = tick_cnt; l0 = ld_cnt;
        cyc(10);
        chk("run_first_tick_cnt", tick_cnt - t0, 1);
        chk("run_first_tick_edge", tick_edge - e0, 9);
        cyc(25);
        chk("run_tick_cnt", tick_cnt - t0, 3);
        chk("run_last_tick_edge", tick_edge - e0, 29);
        chk("run_no_load", ld_cnt - l0, 0);
        chk("run_mode", mode, 0);

        // Enter adjust mode
        adjust = 1'b1;
        sw = 6'd45;
        cyc(4);
        chk("adj_h_mode", mode, 1);
        chk("adj_h_mask", blink_mask, 3'b100);
        chk("adj_h_tick", tick, 0);

        // Hours: 45 clamps to 23
        l0 = ld_cnt; set = 1'b1; e0 = edge_cnt;
        cyc(8); set = 1'b0; cyc(8);
        chk("h_load_cnt", ld_cnt - l0, 1);
        chk("h_latency", ld_edge - e0, 6);
        chk("h_field", ld_f, 0);
        chk("h_tens", ld_t, 2);
        chk("h_units", ld_u, 3);
        chk("h_mode", mode, 2);

        // Minutes: 7
        l0 = ld_cnt; sw = 6'd7; set = 1'b1;
        cyc(8); set = 1'b0; cyc(8);
        chk("m_load_cnt", ld_cnt - l0, 1);
        chk("m_field", ld_f, 1);
        chk("m_tens", ld_t, 0);
        chk("m_units", ld_u, 7);
        chk("m_mode", mode, 3);

        // Seconds: 63 clamps to 59, mode wraps to hours
        l0 = ld_cnt; sw = 6'd63; set = 1'b1;
        cyc(8); set = 1'b0; cyc(8);
        chk("s_load_cnt", ld_cnt - l0, 1);
        chk("s_field", ld_f, 2);
        chk("s_tens", ld_t, 5);
        chk("s_units", ld_u, 9);
        chk("s_mode_wrap", mode, 1);

        // Bouncing set: toggles every cycle, then held high
        l0 = ld_cnt; sw = 6'd10;
        for (int i = 0; i < 6; i++) begin
            set = (i % 2 == 0);
            cyc(1);
        end
        set = 1'b1; e0 = edge_cnt;
        cyc(6);
        chk("bounce_load_cnt", ld_cnt - l0, 1);
        chk("bounce_latency", ld_edge - e0, 6);
        chk("bounce_tens", ld_t, 1);
        chk("bounce_units", ld_u, 0);
        chk("bounce_mode", mode, 2);

        // Blink in ADJ_M: 4 cycles blanked, 4 cycles shown
        set = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("blink_m_%0d", k), blink_mask, ((k / 4) % 2 == 0) ? 3'b010 : 3'b000);
            cyc(1);
        end
        chk("bounce_single_load", ld_cnt - l0, 1);

        // Adjust dropped in the same cycle as set_pulse: exit wins
        l0 = ld_cnt; t0 = tick_cnt;
        set = 1'b1; e0 = edge_cnt;
        cyc(3);
        adjust = 1'b0;
        cyc(2);
        chk("drop_still_adj", mode, 2);
        cyc(1);
        chk("drop_mode", mode, 0);
        chk("drop_mask", blink_mask, 0);
        chk("drop_load_en", load_en, 0);
        set = 1'b0;
        cyc(10);
        chk("drop_no_load", ld_cnt - l0, 0);
        chk("drop_tick_cnt", tick_cnt - t0, 1);
        chk("drop_tick_edge", tick_edge - e0, 15);

        // Go to ADJ_S (commit minutes with sw=0 so load_field ends at 1)
        adjust = 1'b1; sw = 6'd0;
        cyc(4);
        set = 1'b1; cyc(8); set = 1'b0; cyc(8);
        set = 1'b1; cyc(8); set = 1'b0; cyc(8);
        chk("pre_rst_mode", mode, 3);
        chk("pre_rst_field", load_field, 1);

        // Reset in the middle of a press
        set = 1'b1;
        cyc(3);
        l0 = ld_cnt;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_tick", tick, 0);
        chk("mid_rst_load_en", load_en, 0);
        chk("mid_rst_field", load_field, 0);
        chk("mid_rst_tens", load_tens, 0);
        chk("mid_rst_units", load_units, 0);
        chk("mid_rst_mode", mode, 0);
        chk("mid_rst_mask", blink_mask, 0);
        cyc(3);
        reset = 1'b0;
        cyc(15);
        chk("post_rst_no_load", ld_cnt - l0, 0);
        chk("post_rst_mode", mode, 1);
        set = 1'b0;
        cyc(10);
        chk("post_rel_no_load", ld_cnt - l0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/relogio_ajuste_ctrl.md
Name: relogio_ajuste_ctrl

Overview:
Controller that sequences the hh:mm:ss BCD time-counter datapath. It generates the 1 Hz count enable in run mode. It runs an adjust-mode state machine that selects hours, minutes or seconds with the set button, and commits the switch value as BCD load commands to the selected field. It also drives a blink mask so the display can flash the field being adjusted.

Parameters:
CLK_HZ, 50000000, clk cycles per 1 Hz tick (>=2)
BLINK_DIV, 12500000, clk cycles per blink_state toggle in adjust mode (>=1)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required on set (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
adjust  in  1  raw level; high requests adjust mode
set  in  1  raw push button; rising edge commits the current field and advances to the next
sw  in  6  raw binary value to load (0..63)
tick  out  1  one-cycle count enable to the time counter (run mode only)
load_en  out  1  one-cycle load strobe to the datapath
load_field  out  2  field to load: 0=hours, 1=minutes, 2=seconds
load_tens  out  4  BCD tens digit to load
load_units  out  4  BCD units digit to load
mode  out  2  0=RUN, 1=ADJ_H, 2=ADJ_M, 3=ADJ_S
blink_mask  out  3  bit2=hours, bit1=minutes, bit0=seconds; 1 means blank that pair

Behaviour:
- Reset is reset, asynchronous, active-high; clock is clk. All state updates on the rising edge of clk.
- Reset values: tick=0, load_en=0, load_field=0, load_tens=0, load_units=0, mode=RUN, blink_mask=0. Sync, debounce, prescaler and blink counters clear to 0. Debounced set clears to 0.
- Reset mid-operation aborts any pending load; no load_en is emitted after reset deasserts until a new set press.
- Synchronisation: adjust, set and sw each pass through a 2-flop synchroniser. Only synchronised values are used below.
- Debounce on set: the counter increments each cycle the synchronised set differs from the debounced value, and clears whenever they are equal. When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced value takes the synchronised value on that edge and the counter clears. set_pulse is the rising edge of the debounced value (1 cycle).
- FSM transitions:
  - RUN -> ADJ_H when the synchronised adjust is 1.
  - Any ADJ state -> RUN when the synchronised adjust is 0.
  - With adjust=1: set_pulse in ADJ_H -> ADJ_M, ADJ_M -> ADJ_S, ADJ_S -> ADJ_H (wrap-around).
  - set_pulse in RUN is ignored.
- Commit on set_pulse in an ADJ state: on the same edge as the state advance, register:
  - load_en=1 and load_field = the field being left.
  - value = min(sw, 23) for hours, min(sw, 59) for minutes/seconds.
  - load_tens = value/10 and load_units = value%10.
  - load_en drops the next cycle. load_field/tens/units hold their last values.
- Simultaneous events: if set_pulse and adjust=0 occur in the same cycle, exit to RUN wins; no load, no advance. Leaving adjust mode without a set press discards the switch value.
- Set latency: with set held stable, load_en is high in the cycle following rising edge DEBOUNCE_CYCLES+3 after the raw set rises.
- Prescaler:
  - Counts 0..CLK_HZ-1 only in RUN.
  - tick=1 for exactly the cycle in which the count equals CLK_HZ-1, and the count then wraps to 0.
  - In ADJ states the count is held at 0 and tick=0.
  - After returning to RUN, the first tick occurs CLK_HZ cycles later.
- Blink:
  - In ADJ states, the blink counter counts 0..BLINK_DIV-1, and blink_state toggles on each wrap.
  - blink_state restarts at 1 on every entry into, or advance between, ADJ states, so the new field blanks immediately.
  - blink_mask = one-hot of the current field when blink_state=1, else 0 (registered).
  - In RUN: blink_mask=0, counter and blink_state held at 0.
- mode is the registered FSM state.

Test Plan:
All scenarios use CLK_HZ=10, BLINK_DIV=4, DEBOUNCE_CYCLES=3.
- Reset, then run 35 cycles with adjust=0 -> tick pulses exactly 3 times, every 10 cycles; mode=0, load_en never asserts.
- adjust=1, sw=45, press set (held 8 cycles) -> mode goes 1 to 2, with one load_en pulse: field=0, tens=2, units=3 (clamped 23).
- Continue with sw=7, press set, then sw=63, press set -> loads field=1 value 0/7 and field=2 value 5/9; mode ends at 1 (wrap).
- Set bounce: toggle raw set every cycle for 6 cycles, then hold high -> exactly one load_en, DEBOUNCE_CYCLES+3 edges after the last rise.
- In ADJ_M, observe blink_mask -> 3'b010 for 4 cycles then 3'b000 for 4 cycles, repeating. Drop adjust in the same cycle as set_pulse -> mode=0, no load_en, blink_mask=0, first tick 10 cycles later.
- Assert reset mid-press in ADJ_S -> all outputs 0 immediately; no load_en after release.
